// File: rtl/pipe_control_unit.sv
// Pipelined ARM-subset control unit: decodes in D and carries control through E, M and W; owns the NZCV flags.
// Latency: decode is combinational in D; D->E, E->M and M->W are one edge each, and the flags update on the edge that retires E.
// Backpressure: none. No stall; FlushE loads a bubble into E, and M/W are free-running registers.
//
// Ports: CondD/OpD/FunctD/RdD are instruction fields in D. ALUFlagsE is NZCV from the ALU for the instruction in E.
//        RegSrcD/ImmSrcD are combinational decode. *E outputs come from the E register. *M/*W outputs come from later stages.
// Optional feature: define CTRL_BL_EN to decode BL (link write) and add the WriteLinkW output.
module pipe_control_unit #(
    parameter int ALUCTRL_W = 3,
    parameter bit USE_S_BIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           CondD,
    input  logic [1:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic [3:0]           RdD,
    input  logic [3:0]           ALUFlagsE,
    input  logic                 FlushE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 PCSrcE,
    output logic [3:0]           FlagsQ,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemtoRegM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 PCSrcW
`ifdef CTRL_BL_EN
    ,
    output logic                 WriteLinkW
`endif
);

    typedef struct packed {
        logic [3:0]           cond;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 alu_src;
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 branch;
        logic                 flags_write;
        logic                 pcs;
    } e_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pcs;
    } m_ctrl_t;

    // A bubble never executes: all enables clear and cond = never.
    localparam e_ctrl_t E_BUBBLE = '{cond: 4'hF, default: '0};

    // ---------------- Decode (D) ----------------
    logic [2:0] alu3_d;
    logic       alu_src_d, reg_write_d, mem_write_d, mem_to_reg_d, branch_d, flags_write_d, pcs_d;
`ifdef CTRL_BL_EN
    logic       write_link_d;
`endif

    always_comb begin
        RegSrcD       = 2'b00;
        ImmSrcD       = 2'b00;
        alu3_d        = 3'b000;
        alu_src_d     = 1'b0;
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        branch_d      = 1'b0;
        flags_write_d = 1'b0;
`ifdef CTRL_BL_EN
        write_link_d  = 1'b0;
`endif
        case (OpD)
            2'b00: begin
                alu_src_d     = FunctD[5];
                reg_write_d   = 1'b1;
                flags_write_d = USE_S_BIT & FunctD[0];
                case (FunctD[4:1])
                    4'b0100: alu3_d = 3'b000;
                    4'b0010: alu3_d = 3'b001;
                    4'b0000: alu3_d = 3'b010;
                    4'b1100: alu3_d = 3'b011;
                    4'b1101: alu3_d = 3'b100;
                    4'b1010: begin
                        // CMP: subtract for flags only, independent of the S bit.
                        alu3_d        = 3'b001;
                        reg_write_d   = 1'b0;
                        flags_write_d = 1'b1;
                    end
                    default: begin
                        // Unsupported opcode: must not modify any architectural state.
                        alu3_d        = 3'b000;
                        reg_write_d   = 1'b0;
                        flags_write_d = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                ImmSrcD   = 2'b01;
                alu_src_d = 1'b1;
                if (FunctD[0]) begin
                    mem_to_reg_d = 1'b1;
                    reg_write_d  = 1'b1;
                end else begin
                    RegSrcD     = 2'b10;
                    mem_write_d = 1'b1;
                end
            end
            2'b10: begin
                branch_d  = 1'b1;
                RegSrcD   = 2'b01;
                ImmSrcD   = 2'b10;
                alu_src_d = 1'b1;
`ifdef CTRL_BL_EN
                if (FunctD[4]) begin
                    reg_write_d  = 1'b1;
                    write_link_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase
        // Branches write R15 through PCSrcE, so only non-branch writes to R15 count here.
        pcs_d = reg_write_d & (RdD == 4'd15) & ~branch_d;
    end

    // ---------------- E register ----------------
    e_ctrl_t e_d, e_q;
`ifdef CTRL_BL_EN
    logic write_link_e_d, write_link_e_q;
`endif

    always_comb begin
        e_d = E_BUBBLE;
        if (!FlushE) begin
            e_d.cond        = CondD;
            e_d.alu_ctrl    = ALUCTRL_W'(alu3_d);
            e_d.alu_src     = alu_src_d;
            e_d.reg_write   = reg_write_d;
            e_d.mem_write   = mem_write_d;
            e_d.mem_to_reg  = mem_to_reg_d;
            e_d.branch      = branch_d;
            e_d.flags_write = flags_write_d;
            e_d.pcs         = pcs_d;
        end
`ifdef CTRL_BL_EN
        write_link_e_d = write_link_d & ~FlushE;
`endif
    end

    // ---------------- Condition check (E) ----------------
    logic       cond_ex_e;
    logic       n_flag, z_flag, c_flag, v_flag;
    logic [3:0] flags_d, flags_q;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    always_comb begin
        cond_ex_e = 1'b0;
        case (e_q.cond)
            4'b0000: cond_ex_e = z_flag;
            4'b0001: cond_ex_e = ~z_flag;
            4'b0010: cond_ex_e = c_flag;
            4'b0011: cond_ex_e = ~c_flag;
            4'b0100: cond_ex_e = n_flag;
            4'b0101: cond_ex_e = ~n_flag;
            4'b0110: cond_ex_e = v_flag;
            4'b0111: cond_ex_e = ~v_flag;
            4'b1000: cond_ex_e = c_flag & ~z_flag;
            4'b1001: cond_ex_e = ~c_flag | z_flag;
            4'b1010: cond_ex_e = (n_flag == v_flag);
            4'b1011: cond_ex_e = (n_flag != v_flag);
            4'b1100: cond_ex_e = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex_e = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
        // The flag write of the instruction in E commits even when FlushE is high;
        // the flush only kills the instruction entering E.
        flags_d = (e_q.flags_write & cond_ex_e) ? ALUFlagsE : flags_q;
    end

    // ---------------- M and W registers ----------------
    // Writes are gated here so that nothing downstream of E holds an unexecuted write.
    // Branch/flag-write need no M copy: they are fully consumed in E.
    m_ctrl_t m_d, m_q;
    logic    reg_write_w_d, reg_write_w_q;
    logic    mem_to_reg_w_d, mem_to_reg_w_q;
    logic    pcs_w_d, pcs_w_q;
`ifdef CTRL_BL_EN
    logic    write_link_m_d, write_link_m_q, write_link_w_d, write_link_w_q;
`endif

    always_comb begin
        m_d.reg_write  = e_q.reg_write & cond_ex_e;
        m_d.mem_write  = e_q.mem_write & cond_ex_e;
        m_d.mem_to_reg = e_q.mem_to_reg;
        m_d.pcs        = e_q.pcs & cond_ex_e;
        reg_write_w_d  = m_q.reg_write;
        mem_to_reg_w_d = m_q.mem_to_reg;
        pcs_w_d        = m_q.pcs;
`ifdef CTRL_BL_EN
        write_link_m_d = write_link_e_q & cond_ex_e;
        write_link_w_d = write_link_m_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q            <= E_BUBBLE;
            flags_q        <= 4'b0000;
            m_q            <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            pcs_w_q        <= 1'b0;
        end else begin
            e_q            <= e_d;
            flags_q        <= flags_d;
            m_q            <= m_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            pcs_w_q        <= pcs_w_d;
        end
    end

`ifdef CTRL_BL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_link_e_q <= 1'b0;
            write_link_m_q <= 1'b0;
            write_link_w_q <= 1'b0;
        end else begin
            write_link_e_q <= write_link_e_d;
            write_link_m_q <= write_link_m_d;
            write_link_w_q <= write_link_w_d;
        end
    end
    assign WriteLinkW = write_link_w_q;
`endif

    assign ALUControlE = e_q.alu_ctrl;
    assign ALUSrcE     = e_q.alu_src;
    assign PCSrcE      = e_q.branch & cond_ex_e;
    assign FlagsQ      = flags_q;
    assign RegWriteM   = m_q.reg_write;
    assign MemWriteM   = m_q.mem_write;
    assign MemtoRegM   = m_q.mem_to_reg;
    assign RegWriteW   = reg_write_w_q;
    assign MemtoRegW   = mem_to_reg_w_q;
    assign PCSrcW      = pcs_w_q;

endmodule
